// File: rtl/jedro_1_boot_loader.sv
// rtl/jedro_1_boot_loader.sv - streams a length-prefixed little-endian image into RAM, then releases the core
module jedro_1_boot_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  s_valid_i,
  input  logic [7:0]            s_data_i,
  output logic                  s_ready_o,
  output logic [3:0]            we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  core_rstn_o,
  output logic                  done_o,
  output logic                  err_o
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("jedro_1_boot_loader: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           sh_q, sh_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           idx_q, idx_d;
  logic                  ready_d;
  logic [3:0]            we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  core_rstn_d, done_d, err_d;

  logic        fire;
  logic [31:0] word;
  logic [31:0] byte_off;

  assign fire     = s_valid_i && s_ready_o;
  // Incoming byte completes the word on top of the three bytes already shifted in.
  assign word     = {s_data_i, sh_q};
  assign byte_off = idx_q << 2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ready_d     = s_ready_o;
    we_d        = 4'h0;
    addr_d      = addr_o;
    wdata_d     = wdata_o;
    done_d      = (state_q == S_DONE);
    core_rstn_d = (state_q == S_DONE);
    err_d       = (state_q == S_ERR);

    case (state_q)
      S_LEN: begin
        if (fire) begin
          sh_d  = word[31:8];
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            len_d = word;
            idx_d = '0;
            if (word == 32'd0) begin
              state_d = S_DONE;
              ready_d = 1'b0;
            end else if (word > 32'(MAX_WORDS)) begin
              state_d = S_ERR;
              ready_d = 1'b0;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          sh_d  = word[31:8];
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_d    = 4'hF;
            addr_d  = BASE_ADDR + ADDR_WIDTH'(byte_off);
            wdata_d = word;
            idx_d   = idx_q + 32'd1;
            if (idx_q + 32'd1 == len_q) begin
              state_d = S_DONE;
              ready_d = 1'b0;
            end
          end
        end
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_LEN;
      cnt_q       <= '0;
      sh_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      s_ready_o   <= 1'b1;
      we_o        <= 4'h0;
      addr_o      <= '0;
      wdata_o     <= '0;
      core_rstn_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      s_ready_o   <= ready_d;
      we_o        <= we_d;
      addr_o      <= addr_d;
      wdata_o     <= wdata_d;
      core_rstn_o <= core_rstn_d;
      done_o      <= done_d;
      err_o       <= err_d;
    end
  end

endmodule
